// File: rtl/instr_exec_unit.sv
// -----------------------------------------------------------------------------
// instr_exec_unit
//
// Executes one instruction per start/finished handshake. Each instruction
// drives either the VGA pixel port (PLOT, HLINE) or the data-memory port
// (LOAD, STORE, ADDM). Memory reads wait a fixed latency of MEM_RD_LAT cycles
// between presenting an address and sampling mem_output.
//
// Optional feature (macro INSTR_EXEC_CLIP_EN): clips PLOT and HLINE pixels
// whose x is >= SCREEN_W. Without the macro there is no clipping logic.
//
// Ports:
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   start        request to execute instruction (honoured only while finished)
//   instruction  instruction word, latched on acceptance
//   finished     high when idle and ready for a new instruction
//   result       last LOAD / ADDM value
//   x, y, colour pixel coordinates and colour
//   plot         pixel write strobe
//   mem_output   RAM read data
//   mem_address  RAM address
//   mem_data     RAM write data
//   mem_write    RAM write enable
//
// Instruction layout (opcode in the top OPCODE_W bits, fields from LSB up):
//   PLOT/HLINE : x, y, colour, then plot flag (PLOT) or length (HLINE)
//   LOAD/STORE/ADDM : addr, then data/immediate
// -----------------------------------------------------------------------------
module instr_exec_unit #(
    parameter int INSTR_W    = 32,
    parameter int OPCODE_W   = 4,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOUR_W   = 3,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 12,
    parameter int MEM_RD_LAT = 2,
    parameter int SCREEN_W   = 160
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [INSTR_W-1:0]  instruction,
    output logic                finished,
    output logic [DATA_W-1:0]   result,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    input  logic [DATA_W-1:0]   mem_output,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_write
);

    // Field positions
    localparam int Y_LSB    = X_W;
    localparam int C_LSB    = X_W + Y_W;
    localparam int FLAG_BIT = X_W + Y_W + COLOUR_W;
    localparam int LEN_LSB  = X_W + Y_W + COLOUR_W;
    localparam int DATA_LSB = ADDR_W;

    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_PLOT  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_ADDM  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_HLINE = OPCODE_W'(5);

    localparam int LAT_W = $clog2(MEM_RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_RD_LAT);

`ifdef INSTR_EXEC_CLIP_EN
    localparam logic [31:0] SCREEN_LIM = SCREEN_W;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PIX,
        MEM_WAIT,
        RMW_WR,
        LINE,
        FIN
    } state_t;

    state_t             state;
    logic [INSTR_W-1:0] instr_reg;
    logic [LAT_W-1:0]   lat_cnt;
    logic [X_W-1:0]     pix_cnt;   // pixels already emitted by the current HLINE

    // Decode of the incoming word (used only at acceptance)
    logic [OPCODE_W-1:0] in_op;
    logic [X_W-1:0]      in_len;
    assign in_op  = instruction[INSTR_W-1 -: OPCODE_W];
    assign in_len = instruction[LEN_LSB +: X_W];

    // Decode of the latched word
    logic [OPCODE_W-1:0] op;
    logic [X_W-1:0]      f_x;
    logic [Y_W-1:0]      f_y;
    logic [COLOUR_W-1:0] f_colour;
    logic                f_flag;
    logic [X_W-1:0]      f_len;
    logic [ADDR_W-1:0]   f_addr;
    logic [DATA_W-1:0]   f_data;
    assign op       = instr_reg[INSTR_W-1 -: OPCODE_W];
    assign f_x      = instr_reg[X_W-1:0];
    assign f_y      = instr_reg[Y_LSB +: Y_W];
    assign f_colour = instr_reg[C_LSB +: COLOUR_W];
    assign f_flag   = instr_reg[FLAG_BIT];
    assign f_len    = instr_reg[LEN_LSB +: X_W];
    assign f_addr   = instr_reg[ADDR_W-1:0];
    assign f_data   = instr_reg[DATA_LSB +: DATA_W];

    logic [DATA_W-1:0] sum;
    logic [X_W-1:0]    x_inc;
    logic              first_vis;   // first pixel is on screen
    logic              next_vis;    // next HLINE pixel is on screen
    assign sum   = mem_output + f_data;
    assign x_inc = x + X_W'(1);

`ifdef INSTR_EXEC_CLIP_EN
    assign first_vis = (32'(f_x) < SCREEN_LIM);
    assign next_vis  = (32'(x_inc) < SCREEN_LIM);
`else
    assign first_vis = 1'b1;
    assign next_vis  = 1'b1;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            instr_reg   <= '0;
            lat_cnt     <= '0;
            pix_cnt     <= '0;
            finished    <= 1'b1;
            result      <= '0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_write   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // finished is always 1 in IDLE, so start alone accepts
                    if (start) begin
                        instr_reg <= instruction;
                        finished  <= 1'b0;
                        lat_cnt   <= '0;
                        pix_cnt   <= '0;
                        case (in_op)
                            OP_PLOT:                    state <= PIX;
                            OP_LOAD, OP_STORE, OP_ADDM: state <= MEM_WAIT;
                            OP_HLINE:                   state <= (in_len == '0) ? FIN : LINE;
                            default:                    state <= FIN;  // NOP and unknown
                        endcase
                    end
                end

                PIX: begin
                    x      <= f_x;
                    y      <= f_y;
                    colour <= f_colour;
                    plot   <= f_flag & first_vis;
                    state  <= FIN;
                end

                MEM_WAIT: begin
                    if (lat_cnt == '0) begin
                        // First cycle: present the address (and data for STORE)
                        mem_address <= f_addr;
                        lat_cnt     <= lat_cnt + LAT_W'(1);
                        if (op == OP_STORE) begin
                            mem_data  <= f_data;
                            mem_write <= 1'b1;
                            state     <= FIN;
                        end else begin
                            mem_write <= 1'b0;
                        end
                    end else if (lat_cnt == LAT_LAST) begin
                        if (op == OP_ADDM) begin
                            result    <= sum;
                            mem_data  <= sum;
                            mem_write <= 1'b1;
                            state     <= RMW_WR;
                        end else begin
                            result   <= mem_output;
                            finished <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                RMW_WR: begin
                    mem_write <= 1'b0;
                    finished  <= 1'b1;
                    state     <= IDLE;
                end

                LINE: begin
                    if (pix_cnt == '0) begin
                        x       <= f_x;
                        y       <= f_y;
                        colour  <= f_colour;
                        pix_cnt <= X_W'(1);
                        plot    <= first_vis;
                        if (!first_vis) begin
                            state <= FIN;
                        end
                    end else if (pix_cnt < f_len) begin
                        x       <= x_inc;
                        pix_cnt <= pix_cnt + X_W'(1);
                        if (!next_vis) begin
                            // Off-screen pixel ends the line without a pulse
                            plot  <= 1'b0;
                            state <= FIN;
                        end
                    end else begin
                        plot     <= 1'b0;
                        finished <= 1'b1;
                        state    <= IDLE;
                    end
                end

                FIN: begin
                    plot      <= 1'b0;
                    mem_write <= 1'b0;
                    finished  <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit: two instances with read latency 2 (A)
// and 3 (B), each attached to a small behavioural RAM with that latency.
module tb_instr_exec_unit;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start_a, start_b;
    logic [31:0] instruction;

    logic        finished_a, plot_a, mem_write_a;
    logic [11:0] result_a, mem_data_a, mem_output_a;
    logic [7:0]  x_a;
    logic [6:0]  y_a;
    logic [2:0]  colour_a;
    logic [15:0] mem_address_a;

    logic        finished_b, plot_b, mem_write_b;
    logic [11:0] result_b, mem_data_b, mem_output_b;
    logic [7:0]  x_b;
    logic [6:0]  y_b;
    logic [2:0]  colour_b;
    logic [15:0] mem_address_b;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    instr_exec_unit #(.MEM_RD_LAT(2)) dut_a (
        .clock(clock), .resetn(resetn), .start(start_a), .instruction(instruction),
        .finished(finished_a), .result(result_a), .x(x_a), .y(y_a), .colour(colour_a),
        .plot(plot_a), .mem_output(mem_output_a), .mem_address(mem_address_a),
        .mem_data(mem_data_a), .mem_write(mem_write_a)
    );

    instr_exec_unit #(.MEM_RD_LAT(3)) dut_b (
        .clock(clock), .resetn(resetn), .start(start_b), .instruction(instruction),
        .finished(finished_b), .result(result_b), .x(x_b), .y(y_b), .colour(colour_b),
        .plot(plot_b), .mem_output(mem_output_b), .mem_address(mem_address_b),
        .mem_data(mem_data_b), .mem_write(mem_write_b)
    );

    // RAM models: latency L means L-1 register stages after the address register
    logic [11:0] ram_a [0:255];
    logic [11:0] ram_b [0:255];
    logic [11:0] pipe_a, pipe_b0, pipe_b1;
    assign mem_output_a = pipe_a;
    assign mem_output_b = pipe_b1;

    always @(posedge clock) begin
        if (mem_write_a) ram_a[mem_address_a[7:0]] <= mem_data_a;
        if (mem_write_b) ram_b[mem_address_b[7:0]] <= mem_data_b;
        pipe_a  <= ram_a[mem_address_a[7:0]];
        pipe_b0 <= ram_b[mem_address_b[7:0]];
        pipe_b1 <= pipe_b0;
    end

    // Free-running pulse counters; tests compare snapshots
    int plot_pulses_a = 0;
    int wr_pulses_a = 0;
    int wr_pulses_b = 0;
    always @(posedge clock) begin
        if (plot_a === 1'b1) plot_pulses_a <= plot_pulses_a + 1;
        if (mem_write_a === 1'b1) wr_pulses_a <= wr_pulses_a + 1;
        if (mem_write_b === 1'b1) wr_pulses_b <= wr_pulses_b + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns just after the accept edge E0
    task automatic accept_a(input logic [31:0] v);
        start_a = 1'b1;
        instruction = v;
        step();
        start_a = 1'b0;
    endtask

    task automatic accept_b(input logic [31:0] v);
        start_b = 1'b1;
        instruction = v;
        step();
        start_b = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        instruction = '0;
        step();
        step();
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL reset_finished: got %b expected 1", finished_a); end
        compared++; if (plot_a !== 1'b0) begin mismatched++; $display("FAIL reset_plot: got %b expected 0", plot_a); end
        compared++; if (x_a !== 8'd0) begin mismatched++; $display("FAIL reset_x: got %0d expected 0", x_a); end
        compared++; if (result_a !== 12'd0) begin mismatched++; $display("FAIL reset_result: got %h expected 000", result_a); end
        compared++; if (mem_write_a !== 1'b0) begin mismatched++; $display("FAIL reset_mem_write: got %b expected 0", mem_write_a); end
        compared++; if (mem_address_a !== 16'd0) begin mismatched++; $display("FAIL reset_mem_address: got %h expected 0000", mem_address_a); end
        compared++; if (finished_b !== 1'b1) begin mismatched++; $display("FAIL reset_finished_b: got %b expected 1", finished_b); end
        resetn = 1'b1;
        step();
        $display("reset: done");
    endtask

    task automatic test_plot();
        int p0;
        p0 = plot_pulses_a;
        accept_a(32'h1006A20C);   // PLOT x=12 y=34 colour=5 flag=1
        compared++; if (finished_a !== 1'b0) begin mismatched++; $display("FAIL plot_e0_finished: got %b expected 0", finished_a); end
        step();
        compared++; if (plot_a !== 1'b1) begin mismatched++; $display("FAIL plot_e1_plot: got %b expected 1", plot_a); end
        compared++; if (x_a !== 8'd12) begin mismatched++; $display("FAIL plot_x: got %0d expected 12", x_a); end
        compared++; if (y_a !== 7'd34) begin mismatched++; $display("FAIL plot_y: got %0d expected 34", y_a); end
        compared++; if (colour_a !== 3'd5) begin mismatched++; $display("FAIL plot_colour: got %0d expected 5", colour_a); end
        compared++; if (finished_a !== 1'b0) begin mismatched++; $display("FAIL plot_e1_finished: got %b expected 0", finished_a); end
        step();
        compared++; if (plot_a !== 1'b0) begin mismatched++; $display("FAIL plot_e2_plot: got %b expected 0", plot_a); end
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL plot_e2_finished: got %b expected 1", finished_a); end
        compared++; if (plot_pulses_a - p0 !== 1) begin mismatched++; $display("FAIL plot_pulses: got %0d expected 1", plot_pulses_a - p0); end
        $display("plot: x=%0d y=%0d colour=%0d", x_a, y_a, colour_a);
    endtask

    task automatic test_store_load();
        int w0;
        w0 = wr_pulses_a;
        accept_a(32'h3ABC0010);   // STORE addr=0x0010 data=0xABC
        step();
        compared++; if (mem_write_a !== 1'b1) begin mismatched++; $display("FAIL store_e1_write: got %b expected 1", mem_write_a); end
        compared++; if (mem_address_a !== 16'h0010) begin mismatched++; $display("FAIL store_addr: got %h expected 0010", mem_address_a); end
        compared++; if (mem_data_a !== 12'hABC) begin mismatched++; $display("FAIL store_data: got %h expected abc", mem_data_a); end
        step();
        compared++; if (mem_write_a !== 1'b0) begin mismatched++; $display("FAIL store_e2_write: got %b expected 0", mem_write_a); end
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL store_e2_finished: got %b expected 1", finished_a); end
        compared++; if (wr_pulses_a - w0 !== 1) begin mismatched++; $display("FAIL store_pulses: got %0d expected 1", wr_pulses_a - w0); end
        $display("store: addr=%h data=%h", mem_address_a, mem_data_a);

        accept_a(32'h20000010);   // LOAD 0x0010, latency 2
        step();
        compared++; if (mem_address_a !== 16'h0010) begin mismatched++; $display("FAIL load_addr: got %h expected 0010", mem_address_a); end
        compared++; if (mem_write_a !== 1'b0) begin mismatched++; $display("FAIL load_write: got %b expected 0", mem_write_a); end
        step();
        compared++; if (finished_a !== 1'b0) begin mismatched++; $display("FAIL load_e2_finished: got %b expected 0", finished_a); end
        compared++; if (result_a !== 12'h000) begin mismatched++; $display("FAIL load_e2_result: got %h expected 000", result_a); end
        step();
        compared++; if (result_a !== 12'hABC) begin mismatched++; $display("FAIL load_e3_result: got %h expected abc", result_a); end
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL load_e3_finished: got %b expected 1", finished_a); end
        $display("load lat2: result=%h", result_a);

        w0 = wr_pulses_b;
        accept_b(32'h3ABC0010);
        step();
        step();
        compared++; if (finished_b !== 1'b1) begin mismatched++; $display("FAIL store_b_finished: got %b expected 1", finished_b); end
        compared++; if (wr_pulses_b - w0 !== 1) begin mismatched++; $display("FAIL store_b_pulses: got %0d expected 1", wr_pulses_b - w0); end
        accept_b(32'h20000010);   // LOAD 0x0010, latency 3
        step();
        step();
        step();
        compared++; if (finished_b !== 1'b0) begin mismatched++; $display("FAIL load_b_e3_finished: got %b expected 0", finished_b); end
        compared++; if (result_b !== 12'h000) begin mismatched++; $display("FAIL load_b_e3_result: got %h expected 000", result_b); end
        step();
        compared++; if (result_b !== 12'hABC) begin mismatched++; $display("FAIL load_b_e4_result: got %h expected abc", result_b); end
        compared++; if (finished_b !== 1'b1) begin mismatched++; $display("FAIL load_b_e4_finished: got %b expected 1", finished_b); end
        $display("load lat3: result=%h", result_b);
    endtask

    task automatic test_addm();
        int w0;
        w0 = wr_pulses_a;
        accept_a(32'h45450010);   // ADDM addr=0x0010 imm=0x545
        step();
        compared++; if (mem_address_a !== 16'h0010) begin mismatched++; $display("FAIL addm_addr: got %h expected 0010", mem_address_a); end
        compared++; if (mem_write_a !== 1'b0) begin mismatched++; $display("FAIL addm_e1_write: got %b expected 0", mem_write_a); end
        step();
        compared++; if (mem_write_a !== 1'b0) begin mismatched++; $display("FAIL addm_e2_write: got %b expected 0", mem_write_a); end
        step();
        compared++; if (mem_write_a !== 1'b1) begin mismatched++; $display("FAIL addm_e3_write: got %b expected 1", mem_write_a); end
        compared++; if (mem_data_a !== 12'h001) begin mismatched++; $display("FAIL addm_data: got %h expected 001", mem_data_a); end
        compared++; if (result_a !== 12'h001) begin mismatched++; $display("FAIL addm_result: got %h expected 001", result_a); end
        compared++; if (finished_a !== 1'b0) begin mismatched++; $display("FAIL addm_e3_finished: got %b expected 0", finished_a); end
        step();
        compared++; if (mem_write_a !== 1'b0) begin mismatched++; $display("FAIL addm_e4_write: got %b expected 0", mem_write_a); end
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL addm_e4_finished: got %b expected 1", finished_a); end
        compared++; if (mem_address_a !== 16'h0010) begin mismatched++; $display("FAIL addm_addr_hold: got %h expected 0010", mem_address_a); end
        compared++; if (wr_pulses_a - w0 !== 1) begin mismatched++; $display("FAIL addm_pulses: got %0d expected 1", wr_pulses_a - w0); end
        compared++; if (ram_a[16] !== 12'h001) begin mismatched++; $display("FAIL addm_ram: got %h expected 001", ram_a[16]); end
        $display("addm: result=%h", result_a);
    endtask

    task automatic test_hline();
        int p0;
        logic [7:0] exp_x;
        p0 = plot_pulses_a;
`ifdef INSTR_EXEC_CLIP_EN
        accept_a(32'h5029039B);   // HLINE x0=155 y=3 colour=2 L=10
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_x = 8'(155 + k - 1);
            compared++; if (plot_a !== 1'b1) begin mismatched++; $display("FAIL hline_plot k=%0d: got %b expected 1", k, plot_a); end
            compared++; if (x_a !== exp_x) begin mismatched++; $display("FAIL hline_x k=%0d: got %0d expected %0d", k, x_a, exp_x); end
        end
        step();
        compared++; if (plot_a !== 1'b0) begin mismatched++; $display("FAIL hline_clip_plot: got %b expected 0", plot_a); end
        compared++; if (finished_a !== 1'b0) begin mismatched++; $display("FAIL hline_clip_e6_finished: got %b expected 0", finished_a); end
        step();
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL hline_clip_finished: got %b expected 1", finished_a); end
        compared++; if (plot_pulses_a - p0 !== 5) begin mismatched++; $display("FAIL hline_pulses: got %0d expected 5", plot_pulses_a - p0); end
`else
        accept_a(32'h502903FA);   // HLINE x0=250 y=3 colour=2 L=10
        for (int k = 1; k <= 10; k++) begin
            step();
            exp_x = 8'(250 + k - 1);
            compared++; if (plot_a !== 1'b1) begin mismatched++; $display("FAIL hline_plot k=%0d: got %b expected 1", k, plot_a); end
            compared++; if (x_a !== exp_x) begin mismatched++; $display("FAIL hline_x k=%0d: got %0d expected %0d", k, x_a, exp_x); end
        end
        compared++; if (y_a !== 7'd3) begin mismatched++; $display("FAIL hline_y: got %0d expected 3", y_a); end
        compared++; if (finished_a !== 1'b0) begin mismatched++; $display("FAIL hline_e10_finished: got %b expected 0", finished_a); end
        step();
        compared++; if (plot_a !== 1'b0) begin mismatched++; $display("FAIL hline_end_plot: got %b expected 0", plot_a); end
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL hline_end_finished: got %b expected 1", finished_a); end
        compared++; if (plot_pulses_a - p0 !== 10) begin mismatched++; $display("FAIL hline_pulses: got %0d expected 10", plot_pulses_a - p0); end
`endif
        $display("hline: pulses=%0d last_x=%0d", plot_pulses_a - p0, x_a);

        p0 = plot_pulses_a;
        accept_a(32'h500003FA);   // HLINE with L=0
        step();
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL hline0_finished: got %b expected 1", finished_a); end
        compared++; if (plot_pulses_a - p0 !== 0) begin mismatched++; $display("FAIL hline0_pulses: got %0d expected 0", plot_pulses_a - p0); end
        $display("hline L=0: pulses=%0d", plot_pulses_a - p0);
    endtask

    task automatic test_back_to_back();
        int p0, w0;
        p0 = plot_pulses_a;
        w0 = wr_pulses_a;
        instruction = 32'h20000010;   // LOAD 0x0010 (holds 0x001 after ADDM)
        start_a = 1'b1;
        step();                       // E0
        instruction = 32'hF0000000;   // undefined opcode, start kept high
        step();
        compared++; if (finished_a !== 1'b0) begin mismatched++; $display("FAIL b2b_e1_finished: got %b expected 0", finished_a); end
        step();
        compared++; if (finished_a !== 1'b0) begin mismatched++; $display("FAIL b2b_e2_finished: got %b expected 0", finished_a); end
        step();
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL b2b_e3_finished: got %b expected 1", finished_a); end
        compared++; if (result_a !== 12'h001) begin mismatched++; $display("FAIL b2b_load_result: got %h expected 001", result_a); end
        step();
        compared++; if (finished_a !== 1'b0) begin mismatched++; $display("FAIL b2b_accept_finished: got %b expected 0", finished_a); end
        start_a = 1'b0;
        step();
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL b2b_opf_finished: got %b expected 1", finished_a); end
        compared++; if (result_a !== 12'h001) begin mismatched++; $display("FAIL b2b_opf_result: got %h expected 001", result_a); end
        compared++; if (mem_address_a !== 16'h0010) begin mismatched++; $display("FAIL b2b_opf_addr: got %h expected 0010", mem_address_a); end
        compared++; if (wr_pulses_a - w0 !== 0) begin mismatched++; $display("FAIL b2b_writes: got %0d expected 0", wr_pulses_a - w0); end
        compared++; if (plot_pulses_a - p0 !== 0) begin mismatched++; $display("FAIL b2b_plots: got %0d expected 0", plot_pulses_a - p0); end
        $display("back_to_back: result=%h", result_a);
    endtask

    task automatic test_reset_mid_hline();
        int p0;
        accept_a(32'h50CB8500);   // HLINE x0=0 y=5 colour=7 L=50
        repeat (10) step();
        compared++; if (plot_a !== 1'b1) begin mismatched++; $display("FAIL midrst_pre_plot: got %b expected 1", plot_a); end
        compared++; if (x_a !== 8'd9) begin mismatched++; $display("FAIL midrst_pre_x: got %0d expected 9", x_a); end
        #2 resetn = 1'b0;
        #1;
        compared++; if (plot_a !== 1'b0) begin mismatched++; $display("FAIL midrst_plot: got %b expected 0", plot_a); end
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL midrst_finished: got %b expected 1", finished_a); end
        compared++; if (x_a !== 8'd0) begin mismatched++; $display("FAIL midrst_x: got %0d expected 0", x_a); end
        #2 resetn = 1'b1;
        p0 = plot_pulses_a;
        repeat (60) step();
        compared++; if (plot_pulses_a - p0 !== 0) begin mismatched++; $display("FAIL midrst_pulses: got %0d expected 0", plot_pulses_a - p0); end
        compared++; if (finished_a !== 1'b1) begin mismatched++; $display("FAIL midrst_after_finished: got %b expected 1", finished_a); end
        $display("reset mid-hline: pulses after release=%0d", plot_pulses_a - p0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = '0;
            ram_b[i] = '0;
        end
        test_reset();
        test_plot();
        test_store_load();
        test_addm();
        test_hline();
        test_back_to_back();
        test_reset_mid_hline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_exec_unit.md
Name: instr_exec_unit

Overview:
- Parametrised successor of the single-instruction datapath: accepts one instruction per start/finished handshake and drives the VGA pixel port and the data-memory port.
- Adds a configurable memory read latency, a read-modify-write add, and a multi-cycle horizontal-line plot with an internal pixel counter.
- Sits between the sequencer/controller and the framebuffer adapter and data RAM.

Parameters:
- INSTR_W, 32, instruction width; must be >= OPCODE_W+ADDR_W+DATA_W.
- OPCODE_W, 4, opcode field, instruction[INSTR_W-1 -: OPCODE_W].
- X_W, 8, pixel x width.
- Y_W, 7, pixel y width.
- COLOUR_W, 3, colour width.
- ADDR_W, 16, memory address width.
- DATA_W, 12, memory data and result width.
- MEM_RD_LAT, 2, cycles from mem_address registered to mem_output valid; must be >= 1.
- SCREEN_W, 160, visible width; used only by the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request to execute instruction.
- instruction  in  INSTR_W  instruction word, sampled only at acceptance.
- finished  out  1  high when idle and ready.
- result  out  DATA_W  last LOAD/ADDM value.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- colour  out  COLOUR_W  pixel colour.
- plot  out  1  pixel write strobe.
- mem_output  in  DATA_W  RAM read data.
- mem_address  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_write  out  1  RAM write enable.

Behaviour:
- Reset (async, resetn=0): every output goes to 0 except finished=1; state goes to IDLE; the internal pixel counter and latch clear. A reset during any operation aborts it immediately, and no further plot or mem_write pulse occurs.
- Accept: on an edge where finished=1 and start=1, the instruction is latched, finished goes to 0, and the FSM leaves IDLE. Call this edge E0.
- start is ignored while finished=0. Back-to-back instructions need start held or re-asserted, and are accepted one cycle after finished rises.
- Field layout (LSB upward):
  - PLOT/HLINE: x[X_W-1:0], y, colour, then a 1-bit plot flag (PLOT) or an X_W length field (HLINE).
  - LOAD/STORE/ADDM: addr[ADDR_W-1:0], then imm/data[DATA_W-1:0].
- States: IDLE, PIX, MEM_WAIT, RMW_WR, LINE, FIN. FIN sets finished=1 and returns to IDLE.
- Opcode 0, NOP: FIN at E1, so finished=1 after E1.
- Opcode 1, PLOT:
  - E1: x/y/colour load and plot=flag.
  - E2: plot=0, finished=1.
- Opcode 2, LOAD:
  - E1: mem_address=addr, mem_write=0.
  - Edge E1+MEM_RD_LAT: result=mem_output, finished=1.
- Opcode 3, STORE:
  - E1: mem_address, mem_data and mem_write=1.
  - E2: mem_write=0, finished=1.
  - The write pulse is exactly one cycle.
- Opcode 4, ADDM:
  - Read as LOAD.
  - At E1+MEM_RD_LAT: mem_data=mem_output+imm (mod 2^DATA_W), result=the same sum, mem_write=1.
  - Next edge: mem_write=0, finished=1.
  - The address is unchanged throughout.
- Opcode 5, HLINE, length L:
  - L=0 behaves as NOP with no plot pulse.
  - Otherwise, from E1, plot=1 for exactly L consecutive cycles. x starts at x0 and increments by 1 per cycle (wraps mod 2^X_W); y and colour are held.
  - The edge after the last pixel sets plot=0 and finished=1.
- Other opcodes: treated as NOP.
- x, y, colour, mem_address and mem_data hold their last value when not being updated. result changes only on LOAD/ADDM completion.

Optional Feature:
- Macro INSTR_EXEC_CLIP_EN.
- When defined:
  - PLOT with x>=SCREEN_W forces plot=0 for that cycle, with the same timing.
  - HLINE terminates at the first pixel with x>=SCREEN_W: no pulse for that pixel, and finished rises on the following edge. This also prevents wrap-around.
- When undefined: no clipping and no comparator logic; SCREEN_W is unused.

Test Plan:
- Assert resetn mid-HLINE (L=50) at pixel 10 -> plot=0 and finished=1 immediately (async), x=0, and no further pulses after release.
- PLOT x=12 y=34 colour=5 flag=1 -> plot high exactly one cycle with those values; finished=1 two edges after accept.
- STORE addr=0x0010 data=0xABC, then LOAD 0x0010 with MEM_RD_LAT=2 and 3 -> one-cycle mem_write; result=0xABC at E3 and E4 respectively.
- ADDM addr=0x0010 imm=0x545 on a stored 0xABC -> writes 0x001 (wrap), result=0x001, single write pulse.
- HLINE x0=250 y=3 L=10, clip undefined -> 10 pulses with x=250..255,0..3. With INSTR_EXEC_CLIP_EN, x0=155 L=10 -> 5 pulses (x=155..159), then finished.
- start held during a LOAD plus an undefined opcode 0xF -> second instruction accepted only the edge after finished=1; 0xF completes in 1 cycle with no side effects.
